uart_rx_data_sampler: RTL and testbench

UART_RX_DATA_SAMPLER -- requirements
Module: uart_rx_data_sampler

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_edge_bit_counter.sv | 60 ++++++
 rtl/uart_rx_data_sampler.sv | 71 +++++++
 tb/tb_uart_rx_data_sampler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive datapath:
// legal oversampling ratios, frame bit indices and the 2-of-3 vote.
package uart_rx_pkg;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic [3:0] FRAME_LAST_PAR   = 4'd10;
    localparam logic [3:0] FRAME_LAST_NOPAR = 4'd9;

    function automatic logic [3:0] last_bit_idx(input logic par_en);
        return par_en ? FRAME_LAST_PAR : FRAME_LAST_NOPAR;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample-edge and bit-index counters for one UART frame; also reports
// the mid-bit point (half ratio) used by the sampler and the frame-end pulse.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic [PRESCALE_W-1:0] half,
    output logic                  frame_done
);

    logic [PRESCALE_W-1:0] ratio;
    logic [PRESCALE_W-1:0] last_edge;
    logic [3:0]            last_bit;
    logic                  edge_wrap;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        ratio = PRESCALE_W'(PRESCALE_8);
        if (prescale == PRESCALE_W'(PRESCALE_16))
            ratio = PRESCALE_W'(PRESCALE_16);
        else if (prescale == PRESCALE_W'(PRESCALE_32))
            ratio = PRESCALE_W'(PRESCALE_32);
        last_edge = ratio - 1'b1;
        half      = ratio >> 1;
        last_bit  = last_bit_idx(par_en);
        // Compare with >= so a mid-frame ratio/parity change still keeps both counters in range.
        edge_wrap = (edge_cnt >= last_edge);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (edge_wrap) begin
                edge_cnt <= '0;
                if (bit_cnt >= last_bit) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_data_sampler.sv
// UART RX data sampler: takes three samples around each bit centre and
// emits the majority value with a one-cycle valid pulse per frame bit.
module uart_rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  frame_done
);

    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] pos_s0;
    logic [PRESCALE_W-1:0] pos_s1;
    logic [PRESCALE_W-1:0] pos_vote;
    logic                  s0;
    logic                  s1;

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .prescale   (prescale),
        .par_en     (par_en),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .half       (half),
        .frame_done (frame_done)
    );

    always_comb begin
        pos_s0   = half - 1'b1;
        pos_s1   = half;
        pos_vote = half + 1'b1;
    end

    // Samples are only taken while enabled; a restarted frame overwrites s0/s1
    // before the next vote, so a partial vote from an aborted frame is never used.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (enable) begin
                if (edge_cnt == pos_s0)
                    s0 <= rx_in;
                if (edge_cnt == pos_s1)
                    s1 <= rx_in;
                if (edge_cnt == pos_vote) begin
                    sampled_bit  <= majority3(s0, s1, rx_in);
                    sample_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Directed testbench for uart_rx_data_sampler: reset, mid-bit voting,
// frame lengths, enable abort/restart and prescale fallback.
module tb_uart_rx_data_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       sampled_bit;
    logic       sample_valid;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       frame_done;

    int n_pass  = 0;
    int n_total = 0;

    uart_rx_data_sampler #(.PRESCALE_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .par_en       (par_en),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are read on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        enable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; rx_in = 1'b0; prescale = 6'd8; par_en = 1'b0;
        tick(); tick();
        n_total++;
        if ({edge_cnt, bit_cnt, sampled_bit, sample_valid, frame_done} !== {6'd0, 4'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_values: edge=%0d bit=%0d sbit=%b valid=%b done=%b, want 0 0 1 0 0",
                     edge_cnt, bit_cnt, sampled_bit, sample_valid, frame_done);
        else n_pass++;
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_first_sample_p8();
        int n;
        bit found;
        prescale = 6'd8; par_en = 1'b0; rx_in = 1'b0;
        idle_cycle();
        enable = 1'b1;
        found = 1'b0;
        for (n = 1; n <= 20; n++) begin
            tick();
            if (sample_valid) begin found = 1'b1; break; end
        end
        n_total++;
        if (!found || n !== 6)
            $display("FAIL p8_first_valid_cycle: found=%b cycle=%0d, want found at cycle 6", found, n);
        else n_pass++;
        n_total++;
        if ({edge_cnt, bit_cnt, sampled_bit} !== {6'd6, 4'd0, 1'b0})
            $display("FAIL p8_first_valid_state: edge=%0d bit=%0d sbit=%b, want 6 0 0",
                     edge_cnt, bit_cnt, sampled_bit);
        else n_pass++;
        tick();
        n_total++;
        if (sample_valid !== 1'b0)
            $display("FAIL p8_valid_one_cycle: valid=%b, want 0", sample_valid);
        else n_pass++;
    endtask

    task automatic test_glitch_p16();
        int pos;
        prescale = 6'd16; par_en = 1'b0; rx_in = 1'b1;
        idle_cycle();
        enable = 1'b1;
        pos = 0;
        // Bit 0: only the edge 8 sample is low -> vote 1. Bit 1: edges 23 and 25 low -> vote 0.
        while (pos < 26) begin
            rx_in = (pos == 8 || pos == 23 || pos == 25) ? 1'b0 : 1'b1;
            tick();
            pos++;
            if (pos == 10) begin
                n_total++;
                if ({sample_valid, sampled_bit, bit_cnt} !== {1'b1, 1'b1, 4'd0})
                    $display("FAIL p16_glitch_rejected: valid=%b sbit=%b bit=%0d, want 1 1 0",
                             sample_valid, sampled_bit, bit_cnt);
                else n_pass++;
            end
        end
        n_total++;
        if ({sample_valid, sampled_bit, bit_cnt, edge_cnt} !== {1'b1, 1'b0, 4'd1, 6'd10})
            $display("FAIL p16_two_of_three_low: valid=%b sbit=%b bit=%0d edge=%0d, want 1 0 1 10",
                     sample_valid, sampled_bit, bit_cnt, edge_cnt);
        else n_pass++;
    endtask

    task automatic test_frame_p16(input logic par, input int exp_pulses, input int exp_cycles);
        int pulses;
        int done_at;
        int bad_idx;
        prescale = 6'd16; par_en = par; rx_in = 1'b1;
        idle_cycle();
        enable = 1'b1;
        pulses = 0; done_at = -1; bad_idx = 0;
        for (int n = 1; n <= 250; n++) begin
            tick();
            if (sample_valid) begin
                if (bit_cnt !== 4'(pulses)) bad_idx++;
                pulses++;
            end
            if (frame_done) begin done_at = n; break; end
        end
        n_total++;
        if (pulses !== exp_pulses || bad_idx !== 0)
            $display("FAIL frame_pulses_par%0b: pulses=%0d bad_index=%0d, want %0d and 0",
                     par, pulses, bad_idx, exp_pulses);
        else n_pass++;
        n_total++;
        if (done_at !== exp_cycles || edge_cnt !== 6'd0 || bit_cnt !== 4'd0)
            $display("FAIL frame_done_par%0b: done_at=%0d edge=%0d bit=%0d, want %0d 0 0",
                     par, done_at, edge_cnt, bit_cnt, exp_cycles);
        else n_pass++;
        tick();
        n_total++;
        if (frame_done !== 1'b0)
            $display("FAIL frame_done_pulse_par%0b: done=%b, want 0", par, frame_done);
        else n_pass++;
    endtask

    task automatic test_disable_p32();
        int bad_valid;
        prescale = 6'd32; par_en = 1'b0; rx_in = 1'b0;
        idle_cycle();
        enable = 1'b1;
        for (int n = 0; n < 4 * 32 + 20; n++) tick();
        n_total++;
        if ({edge_cnt, bit_cnt, sampled_bit} !== {6'd20, 4'd4, 1'b0})
            $display("FAIL p32_before_abort: edge=%0d bit=%0d sbit=%b, want 20 4 0",
                     edge_cnt, bit_cnt, sampled_bit);
        else n_pass++;
        enable = 1'b0; rx_in = 1'b1;
        tick();
        n_total++;
        if ({edge_cnt, bit_cnt, sample_valid, frame_done, sampled_bit} !== {6'd0, 4'd0, 1'b0, 1'b0, 1'b0})
            $display("FAIL p32_abort: edge=%0d bit=%0d valid=%b done=%b sbit=%b, want 0 0 0 0 0",
                     edge_cnt, bit_cnt, sample_valid, frame_done, sampled_bit);
        else n_pass++;
        bad_valid = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (sample_valid !== 1'b0 || edge_cnt !== 6'd0) bad_valid++;
        end
        n_total++;
        if (bad_valid !== 0 || sampled_bit !== 1'b0)
            $display("FAIL p32_hold_disabled: bad_cycles=%0d sbit=%b, want 0 0", bad_valid, sampled_bit);
        else n_pass++;
        enable = 1'b1;
        tick();
        n_total++;
        if ({edge_cnt, bit_cnt} !== {6'd1, 4'd0})
            $display("FAIL p32_restart: edge=%0d bit=%0d, want 1 0", edge_cnt, bit_cnt);
        else n_pass++;
        for (int n = 1; n < 18; n++) tick();
        n_total++;
        if ({sample_valid, sampled_bit, bit_cnt, edge_cnt} !== {1'b1, 1'b1, 4'd0, 6'd18})
            $display("FAIL p32_restart_sample: valid=%b sbit=%b bit=%0d edge=%0d, want 1 1 0 18",
                     sample_valid, sampled_bit, bit_cnt, edge_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame_p12();
        prescale = 6'd12; par_en = 1'b1; rx_in = 1'b0;
        idle_cycle();
        enable = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        n_total++;
        if ({sample_valid, edge_cnt, sampled_bit} !== {1'b1, 6'd6, 1'b0})
            $display("FAIL p12_as_p8_valid: valid=%b edge=%0d sbit=%b, want 1 6 0",
                     sample_valid, edge_cnt, sampled_bit);
        else n_pass++;
        for (int n = 6; n < 13; n++) tick();
        n_total++;
        if ({edge_cnt, bit_cnt} !== {6'd5, 4'd1})
            $display("FAIL p12_as_p8_count: edge=%0d bit=%0d, want 5 1", edge_cnt, bit_cnt);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_total++;
        if ({edge_cnt, bit_cnt, sampled_bit, sample_valid, frame_done} !== {6'd0, 4'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_mid_frame: edge=%0d bit=%0d sbit=%b valid=%b done=%b, want 0 0 1 0 0",
                     edge_cnt, bit_cnt, sampled_bit, sample_valid, frame_done);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if ({edge_cnt, bit_cnt} !== {6'd1, 4'd0})
            $display("FAIL after_reset_count: edge=%0d bit=%0d, want 1 0", edge_cnt, bit_cnt);
        else n_pass++;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_sample_p8();
        test_glitch_p16();
        test_frame_p16(1'b0, 10, 160);
        test_frame_p16(1'b1, 11, 176);
        test_disable_p32();
        test_reset_mid_frame_p12();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
